// File: rtl/zxuno_uart_serial_engine.sv
// 8N1 serial transceiver for the ZX-UNO UART: TX shifter, RX deserialiser and small RX FIFO.
// TX starts one cycle after txbegin in IDLE; RX bytes show up one cycle after the stop sample; full FIFO drops new bytes.
module zxuno_uart_serial_engine #(
  parameter int CLK_HZ  = 28000000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txdata,
  input  logic       txbegin,
  output logic       txbusy,
  output logic [7:0] rxdata,
  output logic       rx_avail,
  input  logic       data_read,
  output logic       rx_overrun,
  output logic       rx_frmerr,
  output logic       uart_tx,
  input  logic       uart_rx
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CW    = $clog2(DIV);
  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [CW-1:0]    DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]    HALF_LAST = CW'(HALF - 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } ser_state_t;

  // ---------------------------------------------------------------- TX
  ser_state_t    tx_state, tx_state_d;
  logic [CW-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]    tx_bit, tx_bit_d;
  logic [7:0]    tx_sh, tx_sh_d;
  logic          tx_line_d;
  logic          tx_end;

  assign tx_end = (tx_cnt == DIV_LAST);

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    case (tx_state)
      ST_IDLE: begin
        if (txbegin) begin
          tx_state_d = ST_START;
          tx_cnt_d   = '0;
          tx_sh_d    = txdata;
        end
      end
      ST_START: begin
        if (tx_end) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_end) begin
          tx_cnt_d = '0;
          if (tx_bit == 3'd7) begin
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d = tx_bit + 3'd1;
            tx_sh_d  = {1'b0, tx_sh[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_end) begin
          tx_cnt_d = '0;
          // A still-pending request chains straight into the next start bit
          if (txbegin) begin
            tx_state_d = ST_START;
            tx_sh_d    = txdata;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt + 1'b1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase

    tx_line_d = 1'b1;
    if (tx_state_d == ST_START) tx_line_d = 1'b0;
    else if (tx_state_d == ST_DATA) tx_line_d = tx_sh_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'h00;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      uart_tx  <= tx_line_d;
    end
  end

  assign txbusy = (tx_state != ST_IDLE);

  // ---------------------------------------------------------------- RX
  logic          rx_meta, rx_sync, rx_sync_q;
  logic          rx_fall;
  ser_state_t    rx_state, rx_state_d;
  logic [CW-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]    rx_bit, rx_bit_d;
  logic [7:0]    rx_sh, rx_sh_d;
  logic          rx_push, rx_bad;
  logic          rx_end;

  assign rx_fall = rx_sync_q & ~rx_sync;
  assign rx_end  = (rx_cnt == DIV_LAST);

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    rx_push    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
        end
      end
      ST_START: begin
        // Mid-start-bit check rejects short glitches
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_end) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_sync, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state_d = ST_STOP;
          else rx_bit_d = rx_bit + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_end) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          rx_push    = rx_sync;
          rx_bad     = ~rx_sync;
        end else begin
          rx_cnt_d = rx_cnt + 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_state  <= ST_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= 3'd0;
      rx_sh     <= 8'h00;
      rx_frmerr <= 1'b0;
    end else begin
      rx_meta   <= uart_rx;
      rx_sync   <= rx_meta;
      rx_sync_q <= rx_sync;
      rx_state  <= rx_state_d;
      rx_cnt    <= rx_cnt_d;
      rx_bit    <= rx_bit_d;
      rx_sh     <= rx_sh_d;
      rx_frmerr <= rx_bad;
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               data_read_q;
  logic               fifo_full, pop, wr_en;

  assign rx_avail  = (count != '0);
  assign fifo_full = (count == FULL_CNT);
  // The CPU read cycle ends on the falling edge of data_read
  assign pop       = data_read_q & ~data_read & rx_avail;
  assign wr_en     = rx_push & (~fifo_full | pop);
  assign rxdata    = rx_avail ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rx_sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      data_read_q <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      data_read_q <= data_read;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) rx_overrun <= 1'b0;
      else if (rx_push && fifo_full) rx_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zxuno_uart_serial_engine.sv
// Directed bench for zxuno_uart_serial_engine at DIV=16, FIFO depth 4.
module tb_zxuno_uart_serial_engine;
  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] txdata = 8'h00;
  logic       txbegin = 1'b0;
  logic       data_read = 1'b0;
  logic       uart_rx = 1'b1;
  logic       txbusy, rx_avail, rx_overrun, rx_frmerr, uart_tx;
  logic [7:0] rxdata;

  int checks = 0;
  int failures = 0;
  int frmerr_cycles = 0;

  zxuno_uart_serial_engine #(
    .CLK_HZ (1600000),
    .BAUD   (100000),
    .FIFO_AW(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .txdata    (txdata),
    .txbegin   (txbegin),
    .txbusy    (txbusy),
    .rxdata    (rxdata),
    .rx_avail  (rx_avail),
    .data_read (data_read),
    .rx_overrun(rx_overrun),
    .rx_frmerr (rx_frmerr),
    .uart_tx   (uart_tx),
    .uart_rx   (uart_rx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rx_frmerr === 1'b1) frmerr_cycles++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send_rx_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int j = 0; j < 10; j++) begin
      uart_rx = f[j];
      ticks(DIV);
    end
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(3);
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_uart_tx got=%b exp=1", uart_tx); end
    checks++; if (txbusy !== 1'b0) begin failures++; $display("FAIL reset_txbusy got=%b exp=0", txbusy); end
    checks++; if (rx_avail !== 1'b0) begin failures++; $display("FAIL reset_rx_avail got=%b exp=0", rx_avail); end
    checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL reset_rx_overrun got=%b exp=0", rx_overrun); end
    checks++; if (rx_frmerr !== 1'b0) begin failures++; $display("FAIL reset_rx_frmerr got=%b exp=0", rx_frmerr); end
    checks++; if (rxdata !== 8'h00) begin failures++; $display("FAIL reset_rxdata got=%h exp=00", rxdata); end
    rst = 1'b0;
    ticks(2);
    checks++; if ({txbusy, uart_tx} !== 2'b01) begin failures++; $display("FAIL idle_after_reset got=%b exp=01", {txbusy, uart_tx}); end
  endtask

  task automatic test_tx();
    logic [9:0] exp_f;
    exp_f = 10'b1101001010;  // 0xA5 framed, index 0 = start bit
    txdata  = 8'hA5;
    txbegin = 1'b1;
    tick();
    txbegin = 1'b0;
    for (int i = 0; i < 10 * DIV; i++) begin
      checks++;
      if ({txbusy, uart_tx} !== {1'b1, exp_f[i/DIV]}) begin
        failures++;
        $display("FAIL tx_frame cyc=%0d got busy/tx=%b exp=%b", i, {txbusy, uart_tx}, {1'b1, exp_f[i/DIV]});
      end
      tick();
    end
    checks++; if ({txbusy, uart_tx} !== 2'b01) begin failures++; $display("FAIL tx_end got=%b exp=01", {txbusy, uart_tx}); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] f1, f2;
    logic       exp_b;
    f1 = {1'b1, 8'h5A, 1'b0};
    f2 = {1'b1, 8'hC3, 1'b0};
    txdata  = 8'h5A;
    txbegin = 1'b1;
    tick();
    txdata = 8'hC3;
    for (int i = 0; i < 20 * DIV; i++) begin
      if (i == 170) txbegin = 1'b0;
      if (i == 250) txbegin = 1'b1;
      if (i == 253) txbegin = 1'b0;
      exp_b = (i < 10 * DIV) ? f1[i/DIV] : f2[(i-10*DIV)/DIV];
      checks++;
      if ({txbusy, uart_tx} !== {1'b1, exp_b}) begin
        failures++;
        $display("FAIL b2b_frame cyc=%0d got busy/tx=%b exp=%b", i, {txbusy, uart_tx}, {1'b1, exp_b});
      end
      tick();
    end
    checks++; if ({txbusy, uart_tx} !== 2'b01) begin failures++; $display("FAIL b2b_end got=%b exp=01", {txbusy, uart_tx}); end
    ticks(3);
    checks++; if (txbusy !== 1'b0) begin failures++; $display("FAIL b2b_midframe_req got busy=%b exp=0", txbusy); end
  endtask

  task automatic test_rx();
    int base;
    base = frmerr_cycles;
    send_rx_frame(8'h3C, 1'b1);
    tick();
    checks++; if ({rx_avail, rxdata} !== {1'b1, 8'h3C}) begin failures++; $display("FAIL rx_byte got avail=%b data=%h exp 1/3c", rx_avail, rxdata); end
    checks++; if (frmerr_cycles !== base) begin failures++; $display("FAIL rx_no_frmerr got=%0d exp=%0d", frmerr_cycles, base); end
    data_read = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({rx_avail, rxdata} !== {1'b1, 8'h3C}) begin failures++; $display("FAIL rx_hold cyc=%0d got avail=%b data=%h exp 1/3c", k, rx_avail, rxdata); end
    end
    data_read = 1'b0;
    checks++; if (rx_avail !== 1'b1) begin failures++; $display("FAIL rx_fall_cycle got avail=%b exp=1", rx_avail); end
    tick();
    checks++; if (rx_avail !== 1'b0) begin failures++; $display("FAIL rx_popped got avail=%b exp=0", rx_avail); end
  endtask

  task automatic test_overrun();
    for (int v = 1; v <= 5; v++) begin
      if (v == 5) begin
        checks++; if ({rx_avail, rx_overrun} !== 2'b10) begin failures++; $display("FAIL ovr_full_no_flag got avail/ovr=%b exp=10", {rx_avail, rx_overrun}); end
      end
      send_rx_frame(8'(v), 1'b1);
    end
    tick();
    checks++; if ({rx_avail, rx_overrun} !== 2'b11) begin failures++; $display("FAIL ovr_set got avail/ovr=%b exp=11", {rx_avail, rx_overrun}); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({rx_avail, rxdata} !== {1'b1, 8'(k + 1)}) begin failures++; $display("FAIL ovr_pop%0d got avail=%b data=%h exp 1/%h", k, rx_avail, rxdata, 8'(k + 1)); end
      data_read = 1'b1;
      ticks(2);
      data_read = 1'b0;
      tick();
      if (k == 0) begin
        checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", rx_overrun); end
      end
    end
    checks++; if (rx_avail !== 1'b0) begin failures++; $display("FAIL ovr_drained got avail=%b exp=0", rx_avail); end
    data_read = 1'b1;
    ticks(2);
    data_read = 1'b0;
    ticks(2);
    checks++; if ({rx_avail, rx_overrun} !== 2'b00) begin failures++; $display("FAIL pop_empty got avail/ovr=%b exp=00", {rx_avail, rx_overrun}); end
  endtask

  task automatic test_framing();
    int base;
    base = frmerr_cycles;
    send_rx_frame(8'h55, 1'b0);
    ticks(20);
    checks++; if (frmerr_cycles - base !== 1) begin failures++; $display("FAIL frm_pulse got=%0d exp=1", frmerr_cycles - base); end
    checks++; if (rx_avail !== 1'b0) begin failures++; $display("FAIL frm_discard got avail=%b exp=0", rx_avail); end
    // break: line stays low after the bad stop bit
    base = frmerr_cycles;
    send_rx_frame(8'h00, 1'b0);
    uart_rx = 1'b0;
    ticks(3 * DIV);
    uart_rx = 1'b1;
    ticks(20);
    checks++; if (frmerr_cycles - base !== 1) begin failures++; $display("FAIL frm_break got=%0d exp=1", frmerr_cycles - base); end
    checks++; if (rx_avail !== 1'b0) begin failures++; $display("FAIL frm_break_avail got avail=%b exp=0", rx_avail); end
    base = frmerr_cycles;
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    ticks(12 * DIV);
    checks++; if ({rx_avail, rx_overrun} !== 2'b00) begin failures++; $display("FAIL glitch_rx got avail/ovr=%b exp=00", {rx_avail, rx_overrun}); end
    checks++; if (frmerr_cycles !== base) begin failures++; $display("FAIL glitch_frmerr got=%0d exp=%0d", frmerr_cycles, base); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp_f;
    send_rx_frame(8'h11, 1'b1);
    tick();
    checks++; if (rx_avail !== 1'b1) begin failures++; $display("FAIL mid_pre_avail got=%b exp=1", rx_avail); end
    txdata  = 8'h96;
    txbegin = 1'b1;
    uart_rx = 1'b0;
    tick();
    txbegin = 1'b0;
    ticks(69);
    checks++; if ({txbusy, uart_tx} !== 2'b10) begin failures++; $display("FAIL mid_tx_bit3 got=%b exp=10", {txbusy, uart_tx}); end
    rst = 1'b1;
    uart_rx = 1'b1;
    tick();
    checks++; if ({uart_tx, txbusy, rx_avail, rx_overrun} !== 4'b1000) begin failures++; $display("FAIL mid_reset got tx/busy/avail/ovr=%b exp=1000", {uart_tx, txbusy, rx_avail, rx_overrun}); end
    rst = 1'b0;
    ticks(5);
    exp_f = {1'b1, 8'h81, 1'b0};
    txdata  = 8'h81;
    txbegin = 1'b1;
    tick();
    txbegin = 1'b0;
    for (int i = 0; i < 10 * DIV; i++) begin
      checks++;
      if ({txbusy, uart_tx} !== {1'b1, exp_f[i/DIV]}) begin
        failures++;
        $display("FAIL post_reset_tx cyc=%0d got busy/tx=%b exp=%b", i, {txbusy, uart_tx}, {1'b1, exp_f[i/DIV]});
      end
      tick();
    end
    checks++; if (txbusy !== 1'b0) begin failures++; $display("FAIL post_reset_tx_end got busy=%b exp=0", txbusy); end
    send_rx_frame(8'hC7, 1'b1);
    tick();
    checks++; if ({rx_avail, rxdata} !== {1'b1, 8'hC7}) begin failures++; $display("FAIL post_reset_rx got avail=%b data=%h exp 1/c7", rx_avail, rxdata); end
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    tick();
    checks++; if (rx_avail !== 1'b0) begin failures++; $display("FAIL post_reset_pop got avail=%b exp=0", rx_avail); end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx();
    test_overrun();
    test_framing();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
